// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 5;
  localparam int LAST_IDX   = 2**DEF_IDX_W - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer advances only when told a grant was taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  // prio_q = 0 favours requester 0 (A), 1 favours requester 1 (B)
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (upd) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges two register-file write requesters and a bulk clear into one registered write port.
//   state | meaning
//   IDLE  | arbitrating requester writes; clr_req starts a clear
//   CLEAR | writing zero to indices 1..LAST, one per cycle; requesters stalled
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_widx,
  output logic [DATA_W-1:0] rf_wdata
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;

  logic       arb_en;
  logic [1:0] gnt;

  // Arbitration is only offered when a handshake can actually complete this cycle.
  assign arb_en = (state_q == IDLE) && !clr_req && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({b_valid & arb_en, a_valid & arb_en}),
    .upd   (|gnt),
    .gnt   (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign clr_busy = (state_q == CLEAR);
  assign clr_done = done_q;
  assign rf_we    = we_q;
  assign rf_widx  = widx_q;
  assign rf_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = IDX_W'(1);
        end else if (gnt[0]) begin
          widx_d  = a_idx;
          wdata_d = a_data;
          we_d    = (a_idx != '0);
        end else if (gnt[1]) begin
          widx_d  = b_idx;
          wdata_d = b_data;
          we_d    = (b_idx != '0);
        end
      end
      CLEAR: begin
        we_d    = 1'b1;
        widx_d  = cnt_q;
        wdata_d = '0;
        // Counter parks on the last index rather than wrapping to 0.
        if (cnt_q == '1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int IW = DEF_IDX_W;

  logic          clk;
  logic          reset;
  logic          a_valid, b_valid;
  logic [IW-1:0] a_idx, b_idx;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          clr_req, clr_busy, clr_done;
  logic          rf_we;
  logic [IW-1:0] rf_widx;
  logic [DW-1:0] rf_wdata;

  regfile_write_arbiter #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_idx    (a_idx),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_idx    (b_idx),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .rf_we    (rf_we),
    .rf_widx  (rf_widx),
    .rf_wdata (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  bit hs_a    = 1'b0;
  bit hs_b    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: expected registered outputs for the current cycle.
  bit          m_busy  = 1'b0;
  bit          m_fav_b = 1'b0;
  bit          m_we    = 1'b0;
  bit          m_done  = 1'b0;
  int          m_next  = 0;
  int          m_idx   = 0;
  logic [DW-1:0] m_data = '0;
  bit          ea, eb;

  always @(negedge clk) begin
    ea = 1'b0;
    eb = 1'b0;
    if (!reset && !m_busy && !clr_req) begin
      if (a_valid && (!b_valid || !m_fav_b)) ea = 1'b1;
      else if (b_valid) eb = 1'b1;
    end
    if (chk_en) begin
      chk("m_a_ready", a_ready, ea);
      chk("m_b_ready", b_ready, eb);
      chk("m_rf_we", rf_we, m_we);
      chk("m_clr_busy", clr_busy, m_busy);
      chk("m_clr_done", clr_done, m_done);
      if (m_we) begin
        chk("m_rf_widx", rf_widx, m_idx);
        chk("m_rf_wdata", rf_wdata, m_data);
      end
    end
    if (reset) begin
      m_busy  = 1'b0;
      m_fav_b = 1'b0;
      m_we    = 1'b0;
      m_done  = 1'b0;
    end else if (m_busy) begin
      m_we   = 1'b1;
      m_idx  = m_next;
      m_data = '0;
      m_done = (m_next == LAST_IDX);
      if (m_done) m_busy = 1'b0;
      else m_next++;
    end else begin
      m_done = 1'b0;
      m_we   = 1'b0;
      if (clr_req) begin
        m_busy = 1'b1;
        m_next = 1;
      end else if (ea || eb) begin
        m_idx   = ea ? int'(a_idx) : int'(b_idx);
        m_data  = ea ? a_data : b_data;
        m_we    = (m_idx != 0);
        m_fav_b = ea;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int writes, dones, nxt;
  bit found;
  logic [IW-1:0] seq_idx [4];
  bit            seq_a   [4];

  initial begin
    reset = 1'b1; clr_req = 1'b0;
    a_valid = 1'b0; a_idx = '0; a_data = '0;
    b_valid = 1'b0; b_idx = '0; b_data = '0;
    step(); step();
    chk_en = 1'b1;

    // Reset overrides requests and clr_req.
    a_valid = 1'b1; a_idx = 5'd7; a_data = 32'h1;
    b_valid = 1'b1; b_idx = 5'd8; b_data = 32'h2;
    clr_req = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_widx", rf_widx, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    reset = 1'b0; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("post_rst_rf_we", rf_we, 0);

    // Both requesters held valid: A,B,A,B.
    seq_idx[0] = 5'd3; seq_idx[1] = 5'd4; seq_idx[2] = 5'd3; seq_idx[3] = 5'd4;
    seq_a[0] = 1'b1; seq_a[1] = 1'b0; seq_a[2] = 1'b1; seq_a[3] = 1'b0;
    a_valid = 1'b1; a_idx = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_idx = 5'd4; b_data = 32'h44;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_a_ready", a_ready, seq_a[k]);
      chk("rr_b_ready", b_ready, !seq_a[k]);
      step();
      chk("rr_rf_we", rf_we, 1);
      chk("rr_rf_widx", rf_widx, seq_idx[k]);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // A-only write.
    a_valid = 1'b1; a_idx = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    chk("aonly_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("aonly_rf_we", rf_we, 1);
    chk("aonly_rf_widx", rf_widx, 5);
    chk("aonly_rf_wdata", rf_wdata, 32'hDEADBEEF);

    // Index 0 write is swallowed; then B wins when both are valid.
    a_valid = 1'b1; a_idx = 5'd0; a_data = 32'h1234;
    #1;
    chk("idx0_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("idx0_rf_we", rf_we, 0);
    a_valid = 1'b1; a_idx = 5'd6; a_data = 32'h66;
    b_valid = 1'b1; b_idx = 5'd7; b_data = 32'h77;
    #1;
    chk("idx0_next_b_ready", b_ready, 1);
    chk("idx0_next_a_ready", a_ready, 0);
    step();
    b_valid = 1'b0;
    chk("idx0_b_widx", rf_widx, 7);
    #1;
    chk("idx0_then_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("idx0_a_widx", rf_widx, 6);
    chk("idx0_a_wdata", rf_wdata, 32'h66);

    // Clear wins over a simultaneous A request; A is served on the clr_done cycle.
    a_valid = 1'b1; a_idx = 5'd9; a_data = 32'h99; clr_req = 1'b1;
    #1;
    chk("clr_a_ready", a_ready, 0);
    step();
    clr_req = 1'b0;
    nxt = 1; writes = 0; dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      if (rf_we) begin
        chk("clr_widx", rf_widx, nxt);
        chk("clr_wdata", rf_wdata, 0);
        nxt++; writes++;
      end
      if (clr_done) begin
        dones++;
        #1;
        chk("clr_done_a_ready", a_ready, 1);
      end else begin
        chk("clr_busy_mid", clr_busy, 1);
        step();
      end
    end
    chk("clr_writes", writes, 31);
    chk("clr_dones", dones, 1);
    step();
    a_valid = 1'b0;
    chk("clr_after_rf_we", rf_we, 1);
    chk("clr_after_widx", rf_widx, 9);

    // clr_req during a clear is ignored.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    writes = 0; dones = 0;
    for (int i = 0; i < 45; i++) begin
      if (rf_we) writes++;
      if (clr_done) dones++;
      clr_req = (i == 10);
      step();
    end
    clr_req = 1'b0;
    chk("reclr_writes", writes, 31);
    chk("reclr_dones", dones, 1);

    // Reset part way through a clear.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rf_we && rf_widx == 5'd10) found = 1'b1;
      else step();
    end
    chk("abort_reached_10", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rf_we", rf_we, 0);
    chk("abort_clr_busy", clr_busy, 0);
    writes = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (rf_we) writes++;
      if (clr_done) dones++;
      step();
    end
    chk("abort_no_writes", writes, 0);
    chk("abort_no_done", dones, 0);

    // Random traffic; requests held until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!a_valid || hs_a) begin
        a_valid = ($urandom_range(2) != 0);
        a_idx   = ($urandom_range(7) == 0) ? 5'd0 : IW'($urandom);
        a_data  = $urandom;
      end
      if (!b_valid || hs_b) begin
        b_valid = ($urandom_range(2) != 0);
        b_idx   = ($urandom_range(7) == 0) ? 5'd0 : IW'($urandom);
        b_data  = $urandom;
      end
      clr_req = ($urandom_range(49) == 0);
      reset   = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0; clr_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data.
REQ-002 Parameter: IDX_W, 5, width of register index; register count is 2**IDX_W.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid  input  1  requester A has a write pending.
REQ-006 a_idx  input  IDX_W  requester A target index.
REQ-007 a_data  input  DATA_W  requester A write data.
REQ-008 a_ready  output  1  A's request accepted this cycle when a_valid is also high.
REQ-009 b_valid, b_idx, b_data, b_ready  same directions/widths/meaning as A, for requester B.
REQ-010 clr_req  input  1  single-cycle request to zero every register.
REQ-011 clr_busy  output  1  clear sequence in progress.
REQ-012 clr_done  output  1  one-cycle pulse when the clear sequence completes.
REQ-013 rf_we  output  1  register-file write enable (registered).
REQ-014 rf_widx  output  IDX_W  register-file write index (registered).
REQ-015 rf_wdata  output  DATA_W  register-file write data (registered).

Function
REQ-016 FSM has two states, IDLE and CLEAR; the block issues at most one register-file write per cycle.
REQ-017 In IDLE with clr_req low: if only one requester is valid, assert that requester's ready combinationally in the same cycle.
REQ-018 In IDLE with both requesters valid: grant round-robin, favouring the requester not granted most recently; assert ready for the winner only.
REQ-019 The priority pointer updates only on a completed handshake; after reset it favours A.
REQ-020 A handshake (valid and ready both high) drives rf_we=1, rf_widx=idx and rf_wdata=data on the next rising edge (one-cycle latency); rf_we=0 in any cycle with no handshake.
REQ-021 A handshake with idx==0 completes normally but produces rf_we=0 (register 0 is read-only zero); the pointer still updates.
REQ-022 Requesters hold valid, idx and data stable until ready; the block never drops or duplicates an accepted request.
REQ-023 In IDLE, clr_req=1 takes priority over requesters: both readies are low that cycle, and the FSM enters CLEAR on the next edge with the index counter set to 1.
REQ-024 In CLEAR: clr_busy=1; a_ready=b_ready=0; each cycle issues rf_we=1, rf_widx=counter, rf_wdata=0, then increments the counter.
REQ-025 The write with counter==2**IDX_W-1 (31) is the last one; the counter never wraps to 0. The FSM returns to IDLE on the following edge with clr_done=1 for exactly that one cycle.
REQ-026 A clear occupies 31 consecutive write cycles, indices 1..31 in ascending order.
REQ-027 clr_req asserted while in CLEAR is ignored and is not queued.
REQ-028 Requests may be granted in the same cycle that clr_done is high.

Reset
REQ-029 Reset values: FSM=IDLE; pointer favours A; counter=0; rf_we=0; rf_widx=0; rf_wdata=0; clr_busy=0; clr_done=0; a_ready=b_ready=0 while reset is high.
REQ-030 Reset asserted during CLEAR aborts the sequence: no clr_done pulse and no further clear writes.
REQ-031 Reset overrides any simultaneous handshake or clr_req; no rf_we pulse follows the reset cycle.

Structure
REQ-032 Shared package regfile_pkg holds DATA_W/IDX_W defaults, the FSM state enum (IDLE, CLEAR) and the constant LAST_IDX=2**IDX_W-1.
REQ-033 Round-robin grant logic is a sub-module rr_arb2 (two requests, two one-hot grants, pointer-update input).
REQ-034 The FSM, clear counter and output registers remain in regfile_write_arbiter.

Verification
REQ-035 A-only write: a_valid=1, a_idx=5, a_data=0xDEADBEEF -> a_ready=1 the same cycle; next cycle rf_we=1, rf_widx=5, rf_wdata=0xDEADBEEF.
REQ-036 Both requesters held valid (A idx 3, B idx 4) for 4 cycles -> grants in order A,B,A,B; rf_widx sequence 3,4,3,4.
REQ-037 A write to idx 0, data 0x1234 -> a_ready=1; next cycle rf_we=0; next grant goes to B when both are valid.
REQ-038 clr_req pulse with a_valid=1 in the same cycle -> a_ready=0; 31 writes of 0x0 to idx 1..31; clr_done pulses once; A is then granted on the clr_done cycle.
REQ-039 clr_req re-pulsed in the middle of a clear -> still exactly 31 writes and one clr_done.
REQ-040 Reset asserted at clear index 10 -> from the next cycle rf_we=0, clr_busy=0, clr_done never pulses.
